// File: rtl/word_pkg.sv
// Shared word-format definitions for the spell-correction front end.
// A word is 24 five-bit letter slots, slot 0 in the least significant bits.
package word_pkg;

    localparam int CHAR_W  = 5;
    localparam int MAX_LEN = 24;
    localparam int WORD_W  = CHAR_W * MAX_LEN;
    localparam int LEN_W   = 5;

    typedef enum logic [1:0] {
        S_COLLECT = 2'd0,
        S_START   = 2'd1,
        S_WAIT    = 2'd2,
        S_CLEAR   = 2'd3
    } state_t;

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [CHAR_W-1:0] char_t;

    localparam char_t CH_EMPTY = 5'd0;
    localparam char_t CH_A     = 5'd1;
    localparam char_t CH_Z     = 5'd26;

    // Only 'a'..'z' occupy a slot; every other code is dropped.
    function automatic logic is_letter(input char_t c);
        return (c >= CH_A) && (c <= CH_Z);
    endfunction

endpackage

// File: rtl/word_slot_buffer.sv
// Letter slot buffer: appends at slot len, deletes slot len-1, clears in one cycle.
// Clear has priority over push, push over pop.
module word_slot_buffer
    import word_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  char_t            i_push_char,
    input  logic             i_pop,
    input  logic             i_clear,
    output word_t            o_word,
    output logic [LEN_W-1:0] o_len,
    output logic             o_full,
    output logic             o_empty
);

    assign o_full  = (o_len == LEN_W'(MAX_LEN));
    assign o_empty = (o_len == '0);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_word <= '0;
            o_len  <= '0;
        end else if (i_clear) begin
            o_word <= '0;
            o_len  <= '0;
        end else if (i_push && !o_full) begin
            o_word[int'(o_len)*CHAR_W +: CHAR_W] <= i_push_char;
            o_len                                <= o_len + LEN_W'(1);
        end else if (i_pop && !o_empty) begin
            // Zero the vacated slot so unused slots always read as empty.
            o_word[(int'(o_len)-1)*CHAR_W +: CHAR_W] <= CH_EMPTY;
            o_len                                    <= o_len - LEN_W'(1);
        end
    end

endmodule

// File: rtl/word_packer.sv
// Collects letters into a word, hands it to Dictionary with a one-cycle start,
// and returns the corrected word (or the original word on timeout).
module word_packer
    import word_pkg::*;
#(
    parameter int TIMEOUT = 1000000
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_char_valid,
    input  logic [CHAR_W-1:0] i_char,
    output logic             o_char_ready,
    input  logic             i_backspace,
    input  logic             i_commit,
    output logic             o_start,
    output logic [WORD_W-1:0] o_word,
    input  logic             i_dict_finish,
    input  logic [WORD_W-1:0] i_dict_word,
    output logic             o_result_valid,
    output logic [WORD_W-1:0] o_result_word,
    output logic             o_timeout,
    output logic [LEN_W-1:0] o_len,
    output logic [1:0]       o_state
);

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    // Handshake: a letter transfers on a cycle where i_char_valid and
    // o_char_ready are both high; valid may be held while ready is low.

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;
    logic             in_collect;
    logic             buf_full;
    logic             buf_empty;
    logic             char_accept;
    logic             buf_push;
    logic             buf_pop;
    logic             buf_clear;
    logic             wait_expire;

    assign in_collect   = (state == S_COLLECT);
    assign o_char_ready = in_collect && !buf_full && !i_backspace && !i_commit;
    assign char_accept  = i_char_valid && o_char_ready;
    assign buf_push     = char_accept && is_letter(i_char);
    assign buf_pop      = in_collect && i_backspace && !i_commit;
    assign buf_clear    = (state == S_CLEAR);
    // The expiring cycle is the one whose increment would reach TIMEOUT-1.
    assign wait_expire  = (wait_cnt == CNT_W'(TIMEOUT - 2));
    assign o_state      = state;

    word_slot_buffer u_buf (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_push      (buf_push),
        .i_push_char (i_char),
        .i_pop       (buf_pop),
        .i_clear     (buf_clear),
        .o_word      (o_word),
        .o_len       (o_len),
        .o_full      (buf_full),
        .o_empty     (buf_empty)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state          <= S_COLLECT;
            wait_cnt       <= '0;
            o_start        <= 1'b0;
            o_result_valid <= 1'b0;
            o_timeout      <= 1'b0;
            o_result_word  <= '0;
        end else begin
            o_start        <= 1'b0;
            o_result_valid <= 1'b0;
            o_timeout      <= 1'b0;
            case (state)
                S_COLLECT: begin
                    if (i_commit && !buf_empty) begin
                        state   <= S_START;
                        o_start <= 1'b1;
                    end
                end
                S_START: begin
                    state    <= S_WAIT;
                    wait_cnt <= '0;
                end
                S_WAIT: begin
                    if (i_dict_finish) begin
                        o_result_word  <= i_dict_word;
                        o_result_valid <= 1'b1;
                        state          <= S_CLEAR;
                    end else if (wait_expire) begin
                        // Give up on Dictionary and pass the typed word through.
                        o_result_word  <= o_word;
                        o_result_valid <= 1'b1;
                        o_timeout      <= 1'b1;
                        state          <= S_CLEAR;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                S_CLEAR: begin
                    state <= S_COLLECT;
                end
                default: begin
                    state <= S_COLLECT;
                end
            endcase
        end
    end

endmodule

// File: doc/word_packer.md
Name: word_packer

Overview:
- Front end of the spell-correction path.
- Accepts recognised letter codes one at a time from the gesture classifier and packs them into the 120-bit word format (24 slots × 5 bits) used by Dictionary.
- Issues the single-cycle start to Dictionary, holds the word stable, and waits for its finish.
- Returns the corrected word downstream, then clears itself for the next word.

Parameters:
- CHAR_W, 5, bits per letter code (0 = empty slot, 1..26 = 'a'..'z').
- MAX_LEN, 24, letter slots per word; WORD_W = CHAR_W*MAX_LEN = 120 (localparam).
- TIMEOUT, 1000000, maximum cycles to wait for Dictionary finish before abandoning.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_char_valid  in  1  letter offered.
- i_char  in  5  letter code.
- o_char_ready  out  1  letter accepted this cycle when high together with i_char_valid.
- i_backspace  in  1  one-cycle pulse: delete last letter.
- i_commit  in  1  one-cycle pulse: send word to Dictionary.
- o_start  out  1  to Dictionary i_start.
- o_word  out  120  to Dictionary i_word.
- i_dict_finish  in  1  from Dictionary o_finish.
- i_dict_word  in  120  from Dictionary o_word.
- o_result_valid  out  1  one-cycle pulse: o_result_word valid.
- o_result_word  out  120  corrected word.
- o_timeout  out  1  one-cycle pulse with o_result_valid when Dictionary timed out.
- o_len  out  5  letters currently buffered.
- o_state  out  2  FSM state, for debug.

Behaviour:
- Reset (async, active-low):
  - state = S_COLLECT.
  - All outputs and buffers are 0 (o_word, o_len, o_result_word, o_start, o_result_valid, o_timeout).
  - Wait counter is 0.
  - Reset mid-handshake abandons the word; Dictionary is reset by the same i_rst_n.
- States, encoded as o_state: S_COLLECT=0, S_START=1, S_WAIT=2, S_CLEAR=3.
- S_COLLECT:
  - o_char_ready = (len < MAX_LEN) && !i_backspace && !i_commit. This is combinational from those inputs.
  - Priority: commit > backspace > char.
  - Accepted char with code 1..26: write it to slot len, i.e. bits [5*len+4 : 5*len], and increment len.
  - Accepted char with code 0 or 27..31: handshake completes, letter discarded, len unchanged.
  - Backspace: if len > 0, zero slot len-1 and decrement len. If len == 0, no-op.
  - Commit: if len > 0, go to S_START. If len == 0, ignore.
  - Full (len == MAX_LEN): ready stays low and the letter stalls upstream. Backspace and commit still operate.
  - Slot 0 is the first letter typed (LSB). Unused slots are 0.
- S_START:
  - o_start = 1 for exactly this one cycle.
  - Next state is S_WAIT; clear the wait counter.
- S_WAIT:
  - o_word is held constant from S_START until leaving S_WAIT.
  - Chars, backspace and commit are ignored (ready = 0).
  - On i_dict_finish: register o_result_word <= i_dict_word, pulse o_result_valid next cycle, go to S_CLEAR.
  - Otherwise increment the counter. On reaching TIMEOUT-1 with no finish: o_result_word <= o_word unchanged, pulse o_result_valid and o_timeout, go to S_CLEAR.
  - Finish in the same cycle as counter expiry: finish wins and o_timeout stays 0.
- S_CLEAR:
  - One cycle. o_word <= 0, len <= 0, ready = 0.
  - Go to S_COLLECT.
  - o_result_word holds until the next result.
- Latency:
  - Commit → o_start: 1 cycle.
  - i_dict_finish → o_result_valid: 1 cycle.
  - Result → ready again: 2 cycles.
- o_len is registered and mirrors len.

Decomposition:
- Package word_pkg:
  - CHAR_W, MAX_LEN, WORD_W.
  - typedef enum logic [1:0] state_t {S_COLLECT, S_START, S_WAIT, S_CLEAR}.
  - typedef logic [WORD_W-1:0] word_t.
  - Letter-code constants CH_EMPTY = 0, CH_A = 1, CH_Z = 26.
- One sub-module, word_slot_buffer:
  - Holds the 120-bit buffer and len.
  - Supports push, pop and clear.
  - Reports full and empty.
- The FSM and timeout counter stay in word_packer.

Test Plan:
1. Type "cat" (3, 1, 20), then commit → o_word = 120'h5023 and o_len = 3. o_start is high for one cycle, one cycle after commit. A stub Dictionary returns 120'h5023 two cycles later → o_result_valid pulse with o_result_word = 120'h5023. One cycle after that, o_word = 0 and o_len = 0.
2. Type 3, 1, 5, backspace, 20 → o_word = 120'h5023. Backspace at len 0 → no change. Commit at len 0 → o_start never asserts.
3. Push 25 letters of code 1 → ready drops after 24. o_len = 24, o_word = all slots 5'd1. The 25th letter stalls until a backspace, then is accepted.
4. Char valid together with commit → char not accepted (ready = 0 that cycle) and commit proceeds. Codes 0 and 31 → accepted but o_len unchanged.
5. Stub never finishes, with TIMEOUT = 16 → o_result_valid and o_timeout pulse 16 cycles after o_start. o_result_word equals the committed word.
6. Assert i_rst_n low during S_WAIT → all outputs 0 immediately. After release, o_state = 0 and ready = 1.
